// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, operator and state encodings for the calculator entry path
package calc_pkg;

    localparam int DEF_DIGITS = 4;
    localparam int BCD_W      = 4 * DEF_DIGITS;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENT_A = 3'd1,
        ST_ENT_B = 3'd2,
        ST_BUSY  = 3'd3,
        ST_SHOW  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_ROOT = 3'd4;

    localparam logic [4:0] KEY_ADD  = 5'd10;
    localparam logic [4:0] KEY_SUB  = 5'd11;
    localparam logic [4:0] KEY_MUL  = 5'd12;
    localparam logic [4:0] KEY_DIV  = 5'd13;
    localparam logic [4:0] KEY_ROOT = 5'd14;
    localparam logic [4:0] KEY_EQ   = 5'd15;
    localparam logic [4:0] KEY_CLR  = 5'd16;
    localparam logic [4:0] KEY_BKSP = 5'd17;

    function automatic int bcd_width(input int digits);
        return 4 * digits;
    endfunction

    // Binary operator keys 10..13 map onto op codes 0..3.
    function automatic logic [2:0] key_to_op(input logic [4:0] code);
        return code[2:0] - 3'd2;
    endfunction

endpackage

// File: rtl/calc_entry_ctrl_if.sv
// rtl/calc_entry_ctrl_if.sv - keypad and ALU handshake bundle for the entry controller
interface calc_entry_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  key_valid;
    logic [4:0]            key_code;
    logic                  alu_start;
    logic                  alu_done;
    logic                  alu_err;
    logic [4*DIGITS-1:0]   alu_result;

    modport master (
        output key_valid, key_code, alu_done, alu_err, alu_result,
        input  alu_start
    );

    modport slave (
        input  key_valid, key_code, alu_done, alu_err, alu_result,
        output alu_start
    );
endinterface

// File: rtl/bcd_digit_shreg.sv
// rtl/bcd_digit_shreg.sv - BCD operand shift register with digit counter and full/empty flags
module bcd_digit_shreg
    import calc_pkg::*;
#(
    parameter  int DIGITS = DEF_DIGITS,
    localparam int W      = bcd_width(DIGITS),
    localparam int CW     = $clog2(DIGITS + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_digit_i,
    input  logic         shift_in_i,
    input  logic         bksp_i,
    input  logic         load_full_i,
    input  logic [3:0]   digit_i,
    input  logic [W-1:0] full_val_i,
    output logic [W-1:0] value_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

    logic [W-1:0]  value_q, value_d;
    logic [CW-1:0] count_q, count_d;

    assign full_o  = (count_q == CNT_MAX);
    assign empty_o = (count_q == '0);
    assign value_o = value_q;

    // Shift-in and backspace guard themselves so callers may issue them blindly.
    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clr_i) begin
            value_d = '0;
            count_d = '0;
        end else if (load_full_i) begin
            value_d = full_val_i;
            count_d = CNT_MAX;
        end else if (load_digit_i) begin
            value_d = W'(digit_i);
            count_d = CW'(1);
        end else if (shift_in_i && !full_o) begin
            value_d = (value_q << 4) | W'(digit_i);
            count_d = count_q + CW'(1);
        end else if (bksp_i && !empty_o) begin
            value_d = value_q >> 4;
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/calc_entry_ctrl.sv
// rtl/calc_entry_ctrl.sv - calculator keypad entry FSM with ALU handshake; CALC_CHAIN_EN enables result chaining from SHOW
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                clk,
    input  logic                rst,
    calc_entry_ctrl_if.slave    bus,
    output logic [2:0]          state,
    output logic [2:0]          op,
    output logic [4*DIGITS-1:0] opnd_a,
    output logic [4*DIGITS-1:0] opnd_b,
    output logic [4*DIGITS-1:0] result_q,
    output logic                err
);

    localparam int W = bcd_width(DIGITS);

    state_e         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   res_q, res_d;
    logic           alu_start_q, alu_start_d;
    logic           err_q, err_d;

    logic a_clr, a_load, a_shift, a_bksp, a_load_full, a_full, a_empty;
    logic b_clr, b_shift, b_bksp, b_full, b_empty;

    logic [4:0] code;
    logic [3:0] digit;
    logic       k_digit, k_binop, k_root, k_eq, k_clr, k_bksp;

    assign code    = bus.key_code;
    assign digit   = code[3:0];
    assign k_digit = bus.key_valid && (code < 5'd10);
    assign k_binop = bus.key_valid && (code >= KEY_ADD) && (code <= KEY_DIV);
    assign k_root  = bus.key_valid && (code == KEY_ROOT);
    assign k_eq    = bus.key_valid && (code == KEY_EQ);
    assign k_clr   = bus.key_valid && (code == KEY_CLR);
    assign k_bksp  = bus.key_valid && (code == KEY_BKSP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (k_clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (k_digit) state_d = ST_ENT_A;
                ST_ENT_A: begin
                    if (k_binop && !a_empty)     state_d = ST_ENT_B;
                    else if (k_root && !a_empty) state_d = ST_BUSY;
                end
                ST_ENT_B: if (k_eq && !b_empty) state_d = ST_ENT_B == state_q ? ST_BUSY : state_q;
                ST_BUSY:  if (bus.alu_done) state_d = bus.alu_err ? ST_ERR : ST_SHOW;
                ST_SHOW: begin
                    if (k_digit) state_d = ST_ENT_A;
`ifdef CALC_CHAIN_EN
                    else if (k_binop) state_d = ST_ENT_B;
                    else if (k_root)  state_d = ST_BUSY;
`endif
                end
                ST_ERR:   state_d = ST_ERR;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        a_clr       = 1'b0;
        a_load      = 1'b0;
        a_shift     = 1'b0;
        a_bksp      = 1'b0;
        a_load_full = 1'b0;
        b_clr       = 1'b0;
        b_shift     = 1'b0;
        b_bksp      = 1'b0;
        op_d        = op_q;
        res_d       = res_q;
        if (k_clr) begin
            a_clr = 1'b1;
            b_clr = 1'b1;
            op_d  = OP_ADD;
        end else begin
            case (state_q)
                ST_IDLE: if (k_digit) begin
                    a_load = 1'b1;
                    b_clr  = 1'b1;
                end
                ST_ENT_A: begin
                    a_shift = k_digit && !a_full;
                    a_bksp  = k_bksp;
                    if (k_binop && !a_empty)     op_d = key_to_op(code);
                    else if (k_root && !a_empty) op_d = OP_ROOT;
                end
                ST_ENT_B: begin
                    b_shift = k_digit && !b_full;
                    b_bksp  = k_bksp;
                    if (k_binop) op_d = key_to_op(code);
                end
                // A clear in the same cycle never reaches here, so the result is dropped.
                ST_BUSY: if (bus.alu_done && !bus.alu_err) res_d = bus.alu_result;
                ST_SHOW: begin
                    if (k_digit) begin
                        a_load = 1'b1;
                        b_clr  = 1'b1;
                    end
`ifdef CALC_CHAIN_EN
                    else if (k_binop) begin
                        a_load_full = 1'b1;
                        b_clr       = 1'b1;
                        op_d        = key_to_op(code);
                    end else if (k_root) begin
                        a_load_full = 1'b1;
                        op_d        = OP_ROOT;
                    end
`endif
                end
                default: ;
            endcase
        end
        alu_start_d = (state_d == ST_BUSY) && (state_q != ST_BUSY);
        err_d       = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q        <= OP_ADD;
            res_q       <= '0;
            alu_start_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            op_q        <= op_d;
            res_q       <= res_d;
            alu_start_q <= alu_start_d;
            err_q       <= err_d;
        end
    end

    bcd_digit_shreg #(.DIGITS(DIGITS)) u_opnd_a (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (a_clr),
        .load_digit_i (a_load),
        .shift_in_i   (a_shift),
        .bksp_i       (a_bksp),
        .load_full_i  (a_load_full),
        .digit_i      (digit),
        .full_val_i   (res_q),
        .value_o      (opnd_a),
        .full_o       (a_full),
        .empty_o      (a_empty)
    );

    bcd_digit_shreg #(.DIGITS(DIGITS)) u_opnd_b (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (b_clr),
        .load_digit_i (1'b0),
        .shift_in_i   (b_shift),
        .bksp_i       (b_bksp),
        .load_full_i  (1'b0),
        .digit_i      (digit),
        .full_val_i   ('0),
        .value_o      (opnd_b),
        .full_o       (b_full),
        .empty_o      (b_empty)
    );

    assign state         = state_q;
    assign op            = op_q;
    assign result_q      = res_q;
    assign err           = err_q;
    assign bus.alu_start = alu_start_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb/tb_calc_entry_ctrl.sv - directed self-checking bench for calc_entry_ctrl
module tb_calc_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  state, op;
    logic [15:0] opnd_a, opnd_b, result_q;
    logic        err;
    logic [15:0] exp_res;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    calc_entry_ctrl_if #(.DIGITS(4)) bus ();

    calc_entry_ctrl #(.DIGITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .state    (state),
        .op       (op),
        .opnd_a   (opnd_a),
        .opnd_b   (opnd_b),
        .result_q (result_q),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [4:0] c);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = c;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 5'd0;
    endtask

    task automatic alu(input logic e, input logic [15:0] v);
        @(negedge clk);
        bus.alu_done   = 1'b1;
        bus.alu_err    = e;
        bus.alu_result = v;
        @(negedge clk);
        bus.alu_done   = 1'b0;
        bus.alu_err    = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_code   = 5'd0;
        bus.alu_done   = 1'b0;
        bus.alu_err    = 1'b0;
        bus.alu_result = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_state", state, 3'd0);
        chk("rst_op", op, 3'd0);
        chk("rst_a", opnd_a, 16'h0);
        chk("rst_b", opnd_b, 16'h0);
        chk("rst_res", result_q, 16'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_start", bus.alu_start, 1'b0);
        rst = 1'b1;

        press(5'd1);
        chk("add_s1", state, 3'd1);
        press(5'd2);
        chk("add_a12", opnd_a, 16'h0012);
        press(5'd10);
        chk("add_entb", state, 3'd2);
        chk("add_op", op, 3'd0);
        press(5'd7);
        press(5'd15);
        chk("add_busy", state, 3'd3);
        chk("add_a", opnd_a, 16'h0012);
        chk("add_b", opnd_b, 16'h0007);
        chk("add_start1", bus.alu_start, 1'b1);
        @(negedge clk);
        chk("add_start0", bus.alu_start, 1'b0);
        alu(1'b0, 16'h0019);
        exp_res = 16'h0019;
        chk("add_show", state, 3'd4);
        chk("add_res", result_q, exp_res);
        alu(1'b0, 16'h5555);
        chk("stray_done_res", result_q, exp_res);
        chk("stray_done_st", state, 3'd4);

        press(5'd12);
`ifdef CALC_CHAIN_EN
        chk("chain_st", state, 3'd2);
        chk("chain_a", opnd_a, 16'h0019);
        chk("chain_op", op, 3'd2);
        press(5'd2);
        press(5'd15);
        chk("chain_busy", state, 3'd3);
        chk("chain_a2", opnd_a, 16'h0019);
        chk("chain_b", opnd_b, 16'h0002);
        chk("chain_op2", op, 3'd2);
        alu(1'b0, 16'h0038);
        exp_res = 16'h0038;
        chk("chain_res", result_q, exp_res);
`else
        chk("nochain_st", state, 3'd4);
        chk("nochain_op", op, 3'd0);
        chk("nochain_a", opnd_a, 16'h0012);
`endif
        press(5'd16);
        chk("clr_st", state, 3'd0);
        chk("clr_a", opnd_a, 16'h0);
        chk("clr_b", opnd_b, 16'h0);
        chk("clr_op", op, 3'd0);
        chk("clr_res_kept", result_q, exp_res);

        press(5'd1); press(5'd2); press(5'd3); press(5'd4); press(5'd5);
        chk("lim_a", opnd_a, 16'h1234);
        press(5'd17);
        chk("bksp_a", opnd_a, 16'h0123);
        press(5'd9);
        chk("refill_a", opnd_a, 16'h1239);
        press(5'd15);
        chk("eq_in_a", state, 3'd1);
        press(5'd16);

        press(5'd3);
        press(5'd17);
        chk("empty_a", opnd_a, 16'h0);
        press(5'd10);
        chk("op_empty_st", state, 3'd1);
        press(5'd16);

        press(5'd9);
        chk("root_enta", state, 3'd1);
        press(5'd14);
        chk("root_busy", state, 3'd3);
        chk("root_op", op, 3'd4);
        chk("root_start", bus.alu_start, 1'b1);
        chk("root_b", opnd_b, 16'h0);

        press(5'd16);
        chk("abort_st", state, 3'd0);
        alu(1'b0, 16'h0777);
        chk("abort_st2", state, 3'd0);
        chk("abort_res", result_q, exp_res);
        chk("abort_start", bus.alu_start, 1'b0);

        press(5'd2);
        press(5'd14);
        @(negedge clk);
        bus.key_valid  = 1'b1;
        bus.key_code   = 5'd16;
        bus.alu_done   = 1'b1;
        bus.alu_result = 16'h0999;
        @(negedge clk);
        bus.key_valid  = 1'b0;
        bus.alu_done   = 1'b0;
        chk("same_cyc_st", state, 3'd0);
        chk("same_cyc_res", result_q, exp_res);

        press(5'd8); press(5'd13); press(5'd0); press(5'd15);
        chk("div_busy", state, 3'd3);
        alu(1'b1, 16'h1234);
        chk("err_st", state, 3'd5);
        chk("err_flag", err, 1'b1);
        chk("err_res", result_q, exp_res);
        press(5'd5);
        chk("err_dig_st", state, 3'd5);
        chk("err_dig_a", opnd_a, 16'h0008);
        press(5'd16);
        chk("err_clr_st", state, 3'd0);
        chk("err_clr_flag", err, 1'b0);

        press(5'd4);
        press(5'd5);
        chk("pre_rst_a", opnd_a, 16'h0045);
        #2 rst = 1'b0;
        #1;
        chk("arst_st", state, 3'd0);
        chk("arst_a", opnd_a, 16'h0);
        chk("arst_op", op, 3'd0);
        chk("arst_res", result_q, 16'h0);
        chk("arst_err", err, 1'b0);
        @(negedge clk) rst = 1'b1;

        press(5'd6);
        press(5'd14);
        chk("busy_rst_pre", bus.alu_start, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("busy_rst_start", bus.alu_start, 1'b0);
        chk("busy_rst_st", state, 3'd0);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("busy_rst_start2", bus.alu_start, 1'b0);
        chk("busy_rst_st2", state, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
